// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry add sequencer.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_BITS = 4;

endpackage

// File: rtl/rca_seq_ctrl_rippleca.sv
// rippleca: the shared 4-bit ripple-carry adder stepped by rca_seq_ctrl.
module rippleca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    cout = w_c[4];
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// WIDTH-bit adder built by stepping one rippleca instance over the nibbles, LSB first.
// Define RCA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIB_BITS;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t                r_state;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic                  r_carry;
  logic [IDX_W-1:0]      r_idx;

  logic [NIB_BITS-1:0]   w_a_nib;
  logic [NIB_BITS-1:0]   w_b_nib;
  logic [NIB_BITS-1:0]   w_sum_nib;
  logic                  w_cout_nib;
  logic                  w_last;

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_nib = r_a[i*NIB_BITS +: NIB_BITS];
        w_b_nib = r_b[i*NIB_BITS +: NIB_BITS];
      end
    end
  end

  assign w_last = (r_idx == IDX_W'(NIB - 1));

  rippleca u_add (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_sum_nib),
    .cout (w_cout_nib)
  );

`ifdef RCA_SEQ_OVF_EN
  // Carry into the MSB is recovered from the top bit's sum: c3 = a3 ^ b3 ^ s3.
  logic w_ovf;
  assign w_ovf = (w_a_nib[NIB_BITS-1] ^ w_b_nib[NIB_BITS-1] ^ w_sum_nib[NIB_BITS-1]) ^ w_cout_nib;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= a;
            r_b      <= b;
            r_carry  <= cin;
            r_idx    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NIB; i++) begin
            if (r_idx == IDX_W'(i)) begin
              sum[i*NIB_BITS +: NIB_BITS] <= w_sum_nib;
            end
          end
          r_carry <= w_cout_nib;
          if (w_last) begin
            cout      <= w_cout_nib;
`ifdef RCA_SEQ_OVF_EN
            ovf       <= w_ovf;
`endif
            r_idx     <= '0;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          // A request presented here waits: in_ready only rises on the IDLE entry edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
- Sequencer that computes WIDTH-bit additions by time-multiplexing one instance of the team's 4-bit ripple-carry adder, one nibble per cycle, least significant nibble first.
- Registers operands, steps through the nibbles and feeds the carry back between them. Presents the result through a valid/ready handshake.
- Sits between a requesting datapath and the shared 4-bit adder. Trades latency for area when wide additions are infrequent.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB (localparam), WIDTH/4, number of nibble steps.
- IDX_W (localparam), max(1, clog2(NIB)), width of the nibble index counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  controller can accept a request.
- a  input  WIDTH  operand A; sampled only on acceptance.
- b  input  WIDTH  operand B; sampled only on acceptance.
- cin  input  1  carry-in to nibble 0; sampled only on acceptance.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result; stable while out_valid=1.
- cout  output  1  carry out of the top nibble.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, idx=0, carry register=0, operand registers=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and cin into the carry register, set idx=0, go to RUN. Otherwise stay.
  - RUN: in_ready=0. The adder receives a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry register. Each cycle, write the adder's 4-bit sum into sum[4*idx+:4] and its carry-out into the carry register. Then increment idx. When idx==NIB-1, also load cout from the adder carry-out, clear idx and go to DONE.
  - DONE: out_valid=1. sum and cout are held. On out_ready, go to IDLE and drop out_valid. Otherwise hold indefinitely (backpressure).
- Latency: out_valid rises exactly NIB cycles after the accepting edge. At WIDTH=16, that is 4 cycles.
- Throughput: one operation per NIB+2 cycles minimum. No overlap: in_ready stays low until DONE is handshaken.
- Request validity: in_valid while busy is ignored; the requester must hold it. Changes on a, b and cin after acceptance have no effect.
- Partial result: sum nibbles not yet computed keep the previous result until overwritten. Only the value at out_valid=1 is defined.
- Arithmetic: the result is mod 2^WIDTH and equals a+b+cin. cout is bit WIDTH of the full sum.
- Reset mid-operation: asserting rst_n low in any state immediately forces the reset values. The in-flight operation is discarded and no out_valid is produced.
- Simultaneous events: in IDLE, out_ready is don't-care. In DONE, in_valid is ignored even when out_ready=1 in the same cycle; the next request is accepted no earlier than the following cycle.
- WIDTH=4: NIB=1. RUN lasts one cycle.

Optional Feature:
- Macro: RCA_SEQ_OVF_EN.
- When defined: adds output port ovf (1 bit), the signed two's-complement overflow of the WIDTH-bit add.
  - Computed as carry-into-MSB XOR carry-out-of-MSB, taken from the final nibble step.
  - Registered with sum. Reset to 0. Valid with out_valid.
- When undefined: no ovf port and no related logic. All other behaviour is identical.

Decomposition:
- Package rca_seq_pkg holds:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - constant NIB_BITS=4.
- Sub-module: the existing 4-bit ripple-carry adder, rippleca, instantiated exactly once and fed by the nibble mux.
- The controller itself contains the FSM, nibble index counter, operand registers, carry register and result register.

Test Plan (WIDTH=16):
- Basic add: a=0x0004, b=0x000C, cin=0 -> out_valid 4 cycles after accept; sum=0x0010, cout=0.
- Full carry propagation: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. With RCA_SEQ_OVF_EN: ovf=0.
- Carry-in and saturation: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Signed overflow and backpressure:
  - a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1 (with macro).
  - Hold out_ready=0 for 10 cycles -> sum, cout and out_valid stay stable.
  - Then out_ready=1 -> IDLE next cycle.
- Busy rejection: while busy, present a=0x1234, b=0x1111 with in_valid=1 -> in_ready=0 and the request is not taken. After the DONE handshake it is accepted -> sum=0x2345, cout=0.
- Reset mid-run: accept a=0xAAAA, b=0x5555; pull rst_n low after 2 RUN cycles -> outputs are at reset values immediately. A new request 0x0001+0x0001 then gives sum=0x0002.
